// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the demux dispatch front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

    localparam int N_DEF   = 8;
    localparam int SEL_DEF = 3;
    localparam int W_DEF   = 8;
    localparam int CNT_W   = 16;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_dispatch_if.sv
// Handshake bundle between the single producer, the dispatcher and N consumers.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the producer, out_ready[i] from each consumer.
// Optional field in_dest exists only when DEMUX_ADDR_EN is defined.
interface demux_dispatch_if #(
    parameter int N   = demux_pkg::N_DEF,
    parameter int SEL = demux_pkg::SEL_DEF,
    parameter int W   = demux_pkg::W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
`ifdef DEMUX_ADDR_EN
    logic [SEL-1:0]   in_dest;
`endif
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [N*W-1:0]   out_data;   // channel i at [i*W +: W]

    // master: producer and consumers; slave: the dispatcher
    modport master (
        output in_valid, in_data,
`ifdef DEMUX_ADDR_EN
        output in_dest,
`endif
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  in_valid, in_data,
`ifdef DEMUX_ADDR_EN
        input  in_dest,
`endif
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// Latency: word loaded at edge k is visible (vld=1) right after edge k.
// Backpressure: holds until drain_rdy; a load on the draining cycle reloads in place.
// Ports: clk/rst, load + load_dat (write strobe/word), drain_rdy (consumer ready),
//        vld/dat (held word). Data is kept on drain, only overwritten by a load.
module demux_slot
    import demux_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         drain_rdy,
    output logic         vld,
    output logic [W-1:0] dat
);

    slot_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load)                                state_nxt = FULL;
        else if (state == FULL && drain_rdy)     state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       dat <= '0;
        else if (load) dat <= load_dat;
    end

    assign vld = (state == FULL);

endmodule

// File: rtl/demux_dispatch.sv
// Distributes one valid/ready word stream round-robin (or by in_dest) over N one-entry slots.
// Latency: one cycle from accept to out_valid of the target channel.
// Backpressure: in_ready drops only while the current target slot is full and not draining.
// Ports: clk, rst (async active-high), bus (demux_dispatch_if.slave), sel (next target /
//        status), word_cnt (accepted words, wraps). Macro DEMUX_ADDR_EN selects addressed mode.
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int SEL = SEL_DEF,
    parameter int W   = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    demux_dispatch_if.slave   bus,
    output logic [SEL-1:0]    sel,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [SEL-1:0]         tgt;
    logic                   tgt_ok;
    logic                   accept;
    logic [N-1:0]           load;
    logic [N-1:0]           slot_vld;
    wire  [N-1:0][W-1:0]    slot_dat;

`ifdef DEMUX_ADDR_EN
    assign tgt    = bus.in_dest;
    assign tgt_ok = (32'(bus.in_dest) < 32'(N));  // out-of-range destinations are never accepted
`else
    assign tgt    = sel;
    assign tgt_ok = 1'b1;
`endif

    // Purely from target state and consumer ready; in_valid never feeds in_ready.
    assign bus.in_ready = tgt_ok & (~slot_vld[tgt] | bus.out_ready[tgt]);
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            word_cnt <= '0;
        end else if (accept) begin
            sel      <= (tgt == SEL'(N - 1)) ? '0 : tgt + SEL'(1);
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign load[i] = accept & (tgt == SEL'(i));

        demux_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_dat  (bus.in_data),
            .drain_rdy (bus.out_ready[i]),
            .vld       (slot_vld[i]),
            .dat       (slot_dat[i])
        );
    end

    assign bus.out_valid = slot_vld;
    assign bus.out_data  = slot_dat;

endmodule

// File: tb/tb_demux_dispatch.sv
module tb_demux_dispatch;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sel;
    logic [15:0] word_cnt;

    demux_dispatch_if #(.N(8), .SEL(3), .W(8)) bus ();

    demux_dispatch #(.N(8), .SEL(3), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sel      (sel),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: which channels hold a word, what it is, next target, count.
    bit         m_full [N];
    logic [7:0] m_dat  [N];
    int         m_ptr;
    int         m_cnt;
    bit         last_acc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic check_out();
        logic [7:0] ev;
        for (int i = 0; i < N; i++) ev[i] = m_full[i];
        check("out_valid", bus.out_valid, ev);
        check("sel", sel, m_ptr);
        check("word_cnt", word_cnt, m_cnt);
        for (int i = 0; i < N; i++)
            if (m_full[i]) check("out_data", bus.out_data[i*8 +: 8], m_dat[i]);
    endtask

    // Called at a falling edge: drive, check in_ready and drains, clock, check outputs.
    task automatic cycle(input bit v, input logic [7:0] d, input logic [7:0] ordy, input int dest);
        int t;
        bit rdy;
`ifdef DEMUX_ADDR_EN
        t = (dest < 0) ? m_ptr : dest;
        bus.in_dest = 3'(t);
`else
        t = m_ptr;
`endif
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        rdy = !m_full[t] || ordy[t];
        check("in_ready", bus.in_ready, rdy);
        last_acc = v && rdy;
        for (int i = 0; i < N; i++)
            if (m_full[i] && ordy[i]) check("drain_dat", bus.out_data[i*8 +: 8], m_dat[i]);
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (m_full[i] && ordy[i]) m_full[i] = 1'b0;
        if (last_acc) begin
            m_full[t] = 1'b1;
            m_dat[t]  = d;
            m_cnt     = (m_cnt + 1) % 65536;
            m_ptr     = (t + 1) % N;
        end
        @(negedge clk);
        check_out();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
`ifdef DEMUX_ADDR_EN
        bus.in_dest   = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_sel", sel, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back stream with every consumer ready.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 8'hFF, -1);
        check("cnt_after_8", word_cnt, 8);
        check("sel_wrapped", sel, 0);
        cycle(1'b0, 8'h00, 8'hFF, -1);

        // Channel 2 blocked: A2 held, stall on second pass (AA).
        for (int k = 0; k < 10; k++) cycle(1'b1, 8'(8'hA0 + k), 8'hFB, -1);
        cycle(1'b1, 8'hAA, 8'hFB, -1);
        check("stall_in_ready", bus.in_ready, 0);
        check("hold_a2", bus.out_data[2*8 +: 8], 8'hA2);
        cycle(1'b1, 8'hAA, 8'hFF, -1);
        check("ch2_valid", bus.out_valid[2], 1);
        check("ch2_aa", bus.out_data[2*8 +: 8], 8'hAA);

        // Asynchronous reset mid-stream with a word still held.
        bus.in_valid  = 1'b1;
        bus.out_ready = 8'h00;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_sel", sel, 0);
        check("arst_word_cnt", word_cnt, 0);
        check("arst_in_ready", bus.in_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_out();

        // Fill all slots, then drain-and-reload channel 0 in one cycle.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h31 + i), 8'h00, -1);
        cycle(1'b1, 8'h40, 8'h01, -1);
        check("reload_valid0", bus.out_valid[0], 1);
        check("reload_dat0", bus.out_data[7:0], 8'h40);
        check("reload_cnt", word_cnt, 9);

        // Idle cycles: nothing moves while nobody drains.
        repeat (5) cycle(1'b0, 8'($urandom), 8'h00, -1);
        check("idle_valid", bus.out_valid, 8'hFF);
        cycle(1'b0, 8'h00, 8'hFF, -1);

`ifdef DEMUX_ADDR_EN
        cycle(1'b1, 8'h55, 8'h00, 5);
        check("addr_valid", bus.out_valid, 8'h20);
        check("addr_dat", bus.out_data[5*8 +: 8], 8'h55);
        cycle(1'b1, 8'h66, 8'h00, 5);
        check("addr_block", bus.in_ready, 0);
        cycle(1'b0, 8'h00, 8'hFF, -1);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
`ifdef DEMUX_ADDR_EN
            cycle($urandom_range(0, 3) != 0, 8'($urandom), r, int'($urandom_range(0, 7)));
`else
            cycle($urandom_range(0, 3) != 0, 8'($urandom), r, -1);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

Sequential front end for the 1xN demultiplexer: accepts a single valid/ready input word stream and distributes words to N output channels, each with a one-entry holding register and its own valid/ready handshake. Channel selection is a round-robin pointer (or an explicit destination when compiled in), so this block drives the select and data that the combinational 1xN demux otherwise takes from a testbench. It sits between the single-producer source and the N channel consumers.

## Interface
- N, 8, number of output channels (≥2)
- SEL, 3, select width, equal to clog2(N)
- W, 8, data word width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word this cycle
- in_data  input  W  input word
- in_dest  input  SEL  explicit destination channel (present only with DEMUX_ADDR_EN)
- out_valid  output  N  per-channel word held
- out_ready  input  N  per-channel consumer ready
- out_data  output  N*W  channel i word at bits [i*W +: W]
- sel  output  SEL  current target channel
- word_cnt  output  16  count of accepted words, wraps at 2^16

## Operation
- Target channel t = sel (round-robin), or in_dest when DEMUX_ADDR_EN is defined.
- Per channel: one-entry slot, state EMPTY/FULL.
  - EMPTY→FULL on accept to that channel.
  - FULL→EMPTY on out_valid[i] & out_ready[i] with no accept to i.
  - FULL stays FULL on a same-cycle drain plus accept (slot reloads with the new word).
- in_ready = ~full[t] | out_ready[t]. This path is combinational from out_ready and sel/in_dest, with no path from in_valid.
- Accept = in_valid & in_ready. On accept:
  - slot t loads in_data;
  - word_cnt increments;
  - sel advances (t+1) mod N, so N-1 wraps to 0.
- No accept: sel holds. The pointer does not skip full channels; a stalled target channel stalls the input (strict order).
- out_data[i] holds its value while out_valid[i]=1.
  - Contents are don't-care when the slot is empty.
  - The implementation must not clear out_data on drain.
- Drains on different channels are independent and may all occur in the same cycle.
- Any non-accepting cycle leaves all slots unchanged except for drains.

## Timing
- Reset (async assert, sync-to-clk deassert by the integrator):
  - out_valid=0
  - out_data=0
  - sel=0
  - word_cnt=0
  - in_ready=1
- Latency: a word accepted at edge k has out_valid=1 after edge k (one cycle).
- Throughput: one word per cycle when each target consumer keeps out_ready high.
- Reset mid-operation: held words are discarded and the pointer returns to 0. No output handshake completes in the reset cycle.
- Single-channel full: in_ready=0 only while the current target is full and its out_ready=0.
- in_dest (addressed mode) must be < N. If in_dest ≥ N, in_ready=0 and no accept occurs.

## Configuration
- DEMUX_ADDR_EN defined:
  - the in_dest port exists and t = in_dest;
  - sel still reports the last-accepted destination + 1 mod N, used only as status.
- DEMUX_ADDR_EN undefined:
  - no in_dest port;
  - strict round-robin from channel 0.

## Structure
- Package demux_pkg holds:
  - default constants N_DEF=8, SEL_DEF=3, W_DEF=8, CNT_W=16;
  - a clog2 function;
  - the slot state typedef (EMPTY/FULL).
- Sub-module demux_slot: one channel's holding register with load/drain handshake. It is instantiated N times through a generate loop.
- Top-level logic: pointer, accept, word counter, in_ready mux.

## Test plan
- After reset: out_valid=0, sel=0, in_ready=1. Assert rst mid-stream: all outputs return to reset values asynchronously.
- All out_ready=1, send 0x10..0x17 back to back. Required:
  - out_valid[i] pulses with data 0x10+i, one cycle after each accept;
  - sel wraps 7→0;
  - word_cnt=8.
- out_ready[2]=0, stream 0xA0..0xAA:
  - channel 2 holds 0xA2;
  - the stall happens at the second pass to channel 2 (word 0xAA);
  - raising out_ready[2] drains 0xA2 and accepts 0xAA in the same cycle.
- Channel 0 full with out_ready[0]=1 and in_valid targeting 0 simultaneously: slot reloads, out_valid[0] stays 1, no lost or duplicated word.
- in_valid=0 for 5 cycles: sel and word_cnt unchanged; held words remain until drained.
- With DEMUX_ADDR_EN: in_dest=5, data 0x55 → only out_valid[5]=1 with 0x55. With in_dest=5 again while slot 5 is full and out_ready[5]=0 → in_ready=0.
